msg_en_seq: RTL and testbench
=============================

MSG_EN_SEQ -- requirements
Module: msg_en_seq

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent start requesters, range 1..16.
REQ-002 Parameter ROUNDS, default 64: cycles enable stays high per granted sequence, range 1..2^CNT_W.
REQ-003 Parameter CNT_W, default 7: width of round counter.
REQ-004 Parameter CH_W, default 2: width of chan output; SHALL satisfy 2^CH_W >= CHANNELS.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-007 start  in  CHANNELS  per-channel start request, one bit per channel, level or pulse.
REQ-008 abort  in  1  cancels the running sequence; present only when MSG_EN_ABORT_EN is defined.
REQ-009 enable  out  1  high for exactly ROUNDS consecutive cycles per granted sequence.
REQ-010 chan  out  CH_W  index of the channel owning the current sequence; valid while enable=1.
REQ-011 round  out  CNT_W  round index 0..ROUNDS-1 of the current enable cycle.
REQ-012 busy  out  1  high in RUN and DONE states.
REQ-013 done  out  1  one-cycle pulse after the last enable cycle of a completed sequence.
REQ-014 pending  out  CHANNELS  latched, not-yet-granted requests.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE, registered.
REQ-016 Each cycle, pending[i] SHALL be set by start[i]=1 unless channel i is granted in that same cycle, in which case start[i] is consumed by the grant.
REQ-017 In IDLE, req = pending | start; if req != 0, the block SHALL grant the first set bit at or after rr_ptr (wrapping modulo CHANNELS).
REQ-018 On grant: next state RUN; enable=1, round=0 and chan=granted index from the next cycle; pending[granted] cleared; rr_ptr = (granted+1) mod CHANNELS.
REQ-019 Latency from start sampled high in IDLE with empty pending SHALL be exactly 1 cycle to enable=1.
REQ-020 In RUN, round SHALL increment by 1 per cycle; at round=ROUNDS-1, next state DONE.
REQ-021 In DONE: enable=0, done=1 for one cycle; next state IDLE; round and chan hold their last values.
REQ-022 start on the active channel during RUN or DONE SHALL set its pending bit and is served later; it SHALL NOT extend the current sequence.
REQ-023 ROUNDS=1 SHALL give a single enable cycle, then DONE.
REQ-024 The minimum enable-low gap between back-to-back sequences SHALL be 2 cycles (DONE, IDLE).
REQ-025 enable SHALL be a registered output with no combinational path from start.

Reset
REQ-026 With reset=0 at a rising edge: state=IDLE, enable=0, done=0, busy=0, round=0, chan=0, pending=0, rr_ptr=0.
REQ-027 Reset SHALL override all other inputs, including a start or abort in the same cycle.
REQ-028 Reset mid-RUN SHALL drop enable the next cycle with no done pulse, and discard all pending requests.

Configuration
REQ-029 With MSG_EN_ABORT_EN defined: abort=1 in RUN SHALL move the block to IDLE next cycle, with enable=0, no done pulse, and pending preserved; abort SHALL be ignored in IDLE and DONE.
REQ-030 Without MSG_EN_ABORT_EN: the abort port SHALL be absent and every granted sequence SHALL run to completion.

Verification (CHANNELS=4, ROUNDS=64)
REQ-031 start=4'b0001 for one cycle from IDLE -> enable high 64 cycles with chan=0 and round 0..63, then done=1 for one cycle, busy low after that.
REQ-032 start=4'b1010 for one cycle -> channel 1 served first, pending=4'b1000 during RUN, channel 3 served next, enable low for exactly 2 cycles between sequences.
REQ-033 Round-robin fairness: start held at 4'b1111 -> grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
REQ-034 reset=0 applied at round=30 -> enable=0, pending=0 and done=0 the next cycle; a later start=4'b0100 gives enable with chan=2 after 1 cycle.
REQ-035 With MSG_EN_ABORT_EN defined, abort=1 at round=10 while pending=4'b0100 -> no done pulse, IDLE for one cycle, then channel 2 granted.
REQ-036 ROUNDS=1 build, start=4'b0001 -> exactly one enable cycle with round=0, then done=1.

Source files
------------

// File: rtl/msg_en_seq.sv
// Round-robin start arbiter that drives a fixed-length enable burst per grant.
// Define MSG_EN_ABORT_EN to add the i_abort port (cancel a running burst).
module msg_en_seq #(
  parameter int CHANNELS = 4,
  parameter int ROUNDS   = 64,
  parameter int CNT_W    = 7,
  parameter int CH_W     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_start,
`ifdef MSG_EN_ABORT_EN
  input  logic                i_abort,
`endif
  output logic                o_enable,
  output logic [CH_W-1:0]     o_chan,
  output logic [CNT_W-1:0]    o_round,
  output logic                o_busy,
  output logic                o_done,
  output logic [CHANNELS-1:0] o_pending
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic                r_enable;
  logic                r_done;
  logic                r_busy;
  logic [CNT_W-1:0]    r_round;
  logic [CH_W-1:0]     r_chan;
  logic [CHANNELS-1:0] r_pending;
  logic [CH_W-1:0]     r_rr_ptr;

  logic [CHANNELS-1:0] w_req;
  logic [CHANNELS-1:0] w_gnt_oh;
  logic                w_gnt_vld;
  logic [CH_W-1:0]     w_gnt;
  logic [CH_W-1:0]     w_rr_next;
  logic                w_abort;

`ifdef MSG_EN_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Scan offsets from highest to lowest so the nearest request at/after rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_req     = r_pending | i_start;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (w_req[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(idx);
      end
    end
  end

  assign w_gnt_oh  = w_gnt_vld ? (CHANNELS'(1) << w_gnt) : '0;
  assign w_rr_next = (w_gnt == CH_W'(CHANNELS - 1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_enable  <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_round   <= '0;
      r_chan    <= '0;
      r_pending <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done    <= 1'b0;
          r_pending <= w_req & ~w_gnt_oh;
          if (w_gnt_vld) begin
            r_state  <= S_RUN;
            r_enable <= 1'b1;
            r_busy   <= 1'b1;
            r_round  <= '0;
            r_chan   <= w_gnt;
            r_rr_ptr <= w_rr_next;
          end
        end
        S_RUN: begin
          // New starts, including from the owning channel, queue for a later turn.
          r_pending <= r_pending | i_start;
          if (w_abort) begin
            r_state  <= S_IDLE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_round == CNT_W'(ROUNDS - 1)) begin
            r_state  <= S_DONE;
            r_enable <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_round  <= r_round + 1'b1;
          end
        end
        S_DONE: begin
          r_pending <= r_pending | i_start;
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_enable <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_enable  = r_enable;
  assign o_chan    = r_chan;
  assign o_round   = r_round;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_msg_en_seq.sv
// Bench for msg_en_seq: vector table + grant scoreboard, plus reset/abort/ROUNDS=1 sequences.
module tb_msg_en_seq;

  localparam int ROUNDS = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start, start1;
  logic       abort;
  logic       en, done, busy;
  logic [1:0] chan;
  logic [6:0] round;
  logic [3:0] pend;
  logic       en1, done1, busy1;
  logic [1:0] chan1;
  logic [0:0] round1;
  logic [3:0] pend1;

  always #5 clk = ~clk;

  msg_en_seq #(.CHANNELS(4), .ROUNDS(ROUNDS), .CNT_W(7), .CH_W(2)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
`ifdef MSG_EN_ABORT_EN
    .i_abort(abort),
`endif
    .o_enable(en), .o_chan(chan), .o_round(round), .o_busy(busy),
    .o_done(done), .o_pending(pend));

  msg_en_seq #(.CHANNELS(4), .ROUNDS(1), .CNT_W(1), .CH_W(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
`ifdef MSG_EN_ABORT_EN
    .i_abort(1'b0),
`endif
    .o_enable(en1), .o_chan(chan1), .o_round(round1), .o_busy(busy1),
    .o_done(done1), .o_pending(pend1));

  int npass = 0;
  int ntot  = 0;
  int q[$];
  bit trunc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Scoreboard monitor: grants popped on enable rise, burst shape checked every cycle.
  int  m_cnt = 0, m_gap = 0;
  bit  m_prev_en = 0, m_prev_done = 0, m_exp_gap = 0;
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      m_prev_en = 0; m_prev_done = 0; m_cnt = 0; m_exp_gap = 0; m_gap = 0;
    end else begin
      if (m_prev_done) begin
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
      end
      if (en && !m_prev_en) begin
        chk("grant_expected", q.size() != 0, 1);
        if (q.size() != 0) chk("grant_chan", chan, q.pop_front());
        if (m_exp_gap) chk("b2b_gap", m_gap, 2);
        m_exp_gap = 0;
        m_cnt = 0;
      end
      if (en) begin
        chk("round", round, m_cnt);
        chk("busy_run", busy, 1);
        m_cnt++;
      end else if (m_prev_en) begin
        if (trunc) begin
          chk("abort_no_done", done, 0);
          trunc = 0;
        end else begin
          chk("seq_len", m_cnt, ROUNDS);
          chk("done_pulse", done, 1);
          chk("busy_done", busy, 1);
        end
        m_gap = 0;
        m_exp_gap = (q.size() != 0);
      end
      if (!en) m_gap++;
      m_prev_done = done;
      m_prev_en = en;
    end
  end

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy && !en) ok = 1;
    end
    @(negedge clk);
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_round(input int r);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (en && round == 7'(r)) ok = 1;
    end
    if (!ok) chk("round_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  typedef struct {
    logic [3:0] st;
    int         n;
    logic [7:0] chs;
    logic [3:0] pnd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] c;
    rst_n = 0; start = 4'b1111; start1 = 4'b1111; abort = 0;
    tbl[0] = '{4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000};
    tbl[1] = '{4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1}, 4'b1000};
    tbl[2] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}, 4'b0100};
    tbl[3] = '{4'b0101, 2, {2'd0, 2'd0, 2'd2, 2'd0}, 4'b0100};
    tbl[4] = '{4'b1111, 4, {2'd2, 2'd1, 2'd0, 2'd3}, 4'b0111};

    // Reset with start asserted: reset wins.
    repeat (3) @(negedge clk);
    chk("rst_enable", en, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    chk("rst_chan", chan, 0);
    chk("rst_pending", pend, 0);
    start = 0; start1 = 0;
    @(negedge clk); rst_n = 1;

    foreach (tbl[v]) begin
      c = tbl[v].chs;
      for (int j = 0; j < tbl[v].n; j++) q.push_back(int'(c[2*j +: 2]));
      start = tbl[v].st;
      @(negedge clk);
      start = 0;
      chk("latency_1", en, 1);
      chk("pending_run", pend, tbl[v].pnd);
      wait_idle(400);
    end

    // Reset at round 30 with a queued request: no done, pending discarded.
    q.push_back(0);
    start = 4'b0001;
    @(negedge clk); start = 4'b1000;
    @(negedge clk); start = 4'b0000;
    wait_round(30);
    chk("pend_before_rst", pend, 4'b1000);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_enable", en, 0);
    chk("midrst_pending", pend, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);
    q.push_back(2);
    start = 4'b0100;
    @(negedge clk);
    start = 0;
    chk("post_rst_en", en, 1);
    chk("post_rst_chan", chan, 2);
    wait_idle(200);

    // Fairness with start held: 0,1,2,3,0 from rr_ptr=0.
    do_reset();
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(0);
    start = 4'b1111;
    begin
      bit ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clk);
        if (q.size() == 0) ok = 1;
      end
      if (!ok) chk("rr_timeout", 0, 1);
    end
    chk("rr_last_chan", chan, 0);
    start = 0; rst_n = 0;
    @(negedge clk); rst_n = 1;

`ifdef MSG_EN_ABORT_EN
    q.push_back(0);
    start = 4'b0001;
    @(negedge clk); start = 4'b0100;
    @(negedge clk); start = 4'b0000;
    wait_round(10);
    chk("abort_pend_pre", pend, 4'b0100);
    abort = 1; trunc = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_enable", en, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pend_kept", pend, 4'b0100);
    q.push_back(2);
    @(negedge clk);
    chk("abort_next_en", en, 1);
    chk("abort_next_chan", chan, 2);
    wait_idle(200);
`endif

    // ROUNDS=1 instance: one enable cycle then done.
    start1 = 4'b0001;
    @(negedge clk);
    start1 = 0;
    chk("r1_enable", en1, 1);
    chk("r1_round", round1, 0);
    chk("r1_chan", chan1, 0);
    @(negedge clk);
    chk("r1_enable_off", en1, 0);
    chk("r1_done", done1, 1);
    @(negedge clk);
    chk("r1_done_off", done1, 0);
    chk("r1_busy_off", busy1, 0);
    chk("r1_enable_idle", en1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
